// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner: frame-synchronous data update, hex/BCD glyphs,
// leading-zero blanking, per-digit decimal point and blink, 16-level brightness.
module seg_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int TIME_REF  = 50_000,
    parameter int BLINK_DIV = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4*DIGITS-1:0] data_in,
    input  logic [DIGITS-1:0]   dp_in,
    input  logic                data_vld,
    input  logic                hex_mode,
    input  logic                lz_blank,
    input  logic [DIGITS-1:0]   blink_mask,
    input  logic [3:0]          bright,
    output logic [DIGITS-1:0]   seg_sel,
    output logic [6:0]          seg_ment,
    output logic                seg_dp,
    output logic                frame_tick
);
    localparam int RW = $clog2(TIME_REF);
    localparam int PW = RW + 5;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST   = RW'(TIME_REF - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [RW-1:0]       cnt_ref_q, cnt_ref_d;
    logic [DW-1:0]       cnt_dig_q, cnt_dig_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] active_data_q, active_data_d;
    logic [DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                frame_tick_q, frame_tick_d;
    logic [DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic [6:0]          seg_ment_q, seg_ment_d;
    logic                seg_dp_q, seg_dp_d;

    logic                frame_end;
    logic [PW-1:0]       on_lim;
    logic                bright_on;
    logic                lit;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_lz;

    // zero_above[k]: active nibbles k..DIGITS-1 are all zero
    logic [DIGITS:0]     zero_above;
    logic [DIGITS-1:0]   lz_above;

    assign zero_above[DIGITS] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_lz
            assign zero_above[gi] = zero_above[gi+1] && (active_data_q[4*gi +: 4] == 4'd0);
            if (gi == 0) begin : g_first
                assign lz_above[gi] = 1'b0;
            end else begin : g_rest
                assign lz_above[gi] = zero_above[gi];
            end
        end
    endgenerate

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        if (!hex && (nib > 4'd9)) begin
            g = 7'b1111110;
        end
        return g;
    endfunction

    always_comb begin
        frame_end = (cnt_ref_q == REF_LAST) && (cnt_dig_q == DIG_LAST);

        cnt_ref_d = (cnt_ref_q == REF_LAST) ? '0 : cnt_ref_q + RW'(1);
        cnt_dig_d = cnt_dig_q;
        if (cnt_ref_q == REF_LAST) begin
            cnt_dig_d = (cnt_dig_q == DIG_LAST) ? '0 : cnt_dig_q + DW'(1);
        end

        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        pending_d     = pending_q;
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        if (data_vld) begin
            shadow_data_d = data_in;
            shadow_dp_d   = dp_in;
        end
        // A strobe on the frame-end cycle bypasses the shadow and never leaves pending set
        if (frame_end) begin
            pending_d = 1'b0;
            if (data_vld) begin
                active_data_d = data_in;
                active_dp_d   = dp_in;
            end else if (pending_q) begin
                active_data_d = shadow_data_q;
                active_dp_d   = shadow_dp_q;
            end
        end else if (data_vld) begin
            pending_d = 1'b1;
        end

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        frame_tick_d = frame_end;

        on_lim    = ((PW'(bright) + PW'(1)) * PW'(TIME_REF)) >> 4;
        bright_on = PW'(cnt_ref_q) < on_lim;
        cur_nib   = active_data_q[{cnt_dig_q, 2'b00} +: 4];
        cur_dp    = active_dp_q[cnt_dig_q];
        cur_lz    = lz_above[cnt_dig_q] && !hex_mode && lz_blank;
        lit       = bright_on && !(blink_mask[cnt_dig_q] && blink_phase_q);

        // An LZ-blanked digit stays selected when its decimal point is lit
        seg_sel_d  = '1;
        seg_ment_d = 7'b1111111;
        seg_dp_d   = 1'b1;
        if (lit && (!cur_lz || cur_dp)) begin
            seg_sel_d[cnt_dig_q] = 1'b0;
            seg_dp_d             = ~cur_dp;
            if (!cur_lz) begin
                seg_ment_d = glyph(cur_nib, hex_mode);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_ref_q     <= '0;
            cnt_dig_q     <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            frame_tick_q  <= 1'b0;
            seg_sel_q     <= '1;
            seg_ment_q    <= 7'b1111111;
            seg_dp_q      <= 1'b1;
        end else begin
            cnt_ref_q     <= cnt_ref_d;
            cnt_dig_q     <= cnt_dig_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            frame_tick_q  <= frame_tick_d;
            seg_sel_q     <= seg_sel_d;
            seg_ment_q    <= seg_ment_d;
            seg_dp_q      <= seg_dp_d;
        end
    end

    assign seg_sel    = seg_sel_q;
    assign seg_ment   = seg_ment_q;
    assign seg_dp     = seg_dp_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: table vectors, hand-written frame/blink/brightness
// sequences and a random run, all checked against a cycle-indexed display model.
module tb_seg_scan_ctrl;
    localparam int DIGITS    = 4;
    localparam int TIME_REF  = 16;
    localparam int BLINK_DIV = 2;
    localparam int FRAME     = DIGITS * TIME_REF;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [4*DIGITS-1:0] data_in = '0;
    logic [DIGITS-1:0]   dp_in = '0;
    logic                data_vld = 1'b0;
    logic                hex_mode = 1'b0;
    logic                lz_blank = 1'b0;
    logic [DIGITS-1:0]   blink_mask = '0;
    logic [3:0]          bright = 4'd15;
    logic [DIGITS-1:0]   seg_sel;
    logic [6:0]          seg_ment;
    logic                seg_dp;
    logic                frame_tick;

    seg_scan_ctrl #(.DIGITS(DIGITS), .TIME_REF(TIME_REF), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .data_vld(data_vld),
        .hex_mode(hex_mode), .lz_blank(lz_blank), .blink_mask(blink_mask), .bright(bright),
        .seg_sel(seg_sel), .seg_ment(seg_ment), .seg_dp(seg_dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n = 0;          // clock edges since reset release
    int tick_cnt = 0;
    logic [15:0] disp_data, latest_data;
    logic [3:0]  disp_dp, latest_dp;
    bit          have_latest;
    logic [6:0]  glyph_tab [16];

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        hex;
        logic        lz;
        int          dig;
        logic [3:0]  e_sel;
        logic [6:0]  e_ment;
        logic        e_dp;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
        end
    endtask

    // Display seen after edge 'cyc': slot position from plain arithmetic on the cycle index
    function automatic void expect_out(input int cyc, output logic [3:0] e_sel,
                                       output logic [6:0] e_ment, output logic e_dp,
                                       output logic e_tick);
        int r, d, f, lim;
        bit blink_off, lit, lzb;
        logic [3:0]  nib;
        logic [15:0] upper;
        r   = cyc % TIME_REF;
        d   = (cyc / TIME_REF) % DIGITS;
        f   = cyc / FRAME;
        lim = ((int'(bright) + 1) * TIME_REF) >> 4;
        blink_off = blink_mask[d] && (((f / BLINK_DIV) % 2) == 1);
        lit = (r < lim) && !blink_off;
        nib = disp_data[4*d +: 4];
        upper = disp_data >> (4 * d);
        lzb = !hex_mode && lz_blank && (d != 0) && (upper == 16'h0);
        e_sel  = 4'hF;
        e_ment = 7'b1111111;
        e_dp   = 1'b1;
        e_tick = ((cyc % FRAME) == FRAME - 1);
        if (lit && (!lzb || disp_dp[d])) begin
            e_sel[d] = 1'b0;
            e_dp     = ~disp_dp[d];
            if (!lzb) e_ment = (!hex_mode && nib > 4'd9) ? 7'b1111110 : glyph_tab[nib];
        end
    endfunction

    task automatic step();
        logic [3:0] es;
        logic [6:0] em;
        logic ed, et;
        expect_out(n, es, em, ed, et);
        @(posedge clk);
        if (data_vld) begin
            latest_data = data_in;
            latest_dp   = dp_in;
            have_latest = 1'b1;
        end
        if ((n % FRAME) == FRAME - 1 && have_latest) begin
            disp_data   = latest_data;
            disp_dp     = latest_dp;
            have_latest = 1'b0;
        end
        @(negedge clk);
        chk("model_sel", 32'(seg_sel), 32'(es));
        chk("model_ment", 32'(seg_ment), 32'(em));
        chk("model_dp", 32'(seg_dp), 32'(ed));
        chk("model_tick", 32'(frame_tick), 32'(et));
        if (frame_tick) tick_cnt++;
        n++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_sel", 32'(seg_sel), 32'hF);
        chk("rst_ment", 32'(seg_ment), 32'h7F);
        chk("rst_dp", 32'(seg_dp), 32'h1);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        disp_data = '0;
        disp_dp = '0;
        have_latest = 1'b0;
    endtask

    initial begin
        int c0, c1, dpl1, dplx;
        glyph_tab[0]  = 7'b0000001; glyph_tab[1]  = 7'b1001111;
        glyph_tab[2]  = 7'b0010010; glyph_tab[3]  = 7'b0000110;
        glyph_tab[4]  = 7'b1001100; glyph_tab[5]  = 7'b0100100;
        glyph_tab[6]  = 7'b0100000; glyph_tab[7]  = 7'b0001111;
        glyph_tab[8]  = 7'b0000000; glyph_tab[9]  = 7'b0000100;
        glyph_tab[10] = 7'b0001000; glyph_tab[11] = 7'b1100000;
        glyph_tab[12] = 7'b0110001; glyph_tab[13] = 7'b1000010;
        glyph_tab[14] = 7'b0110000; glyph_tab[15] = 7'b0111000;

        vecs[0] = '{16'h0042, 4'h0, 1'b0, 1'b1, 0, 4'b1110, 7'b0010010, 1'b1};
        vecs[1] = '{16'h0042, 4'h0, 1'b0, 1'b1, 1, 4'b1101, 7'b1001100, 1'b1};
        vecs[2] = '{16'h0042, 4'h0, 1'b0, 1'b1, 2, 4'b1111, 7'b1111111, 1'b1};
        vecs[3] = '{16'h0042, 4'h0, 1'b0, 1'b1, 3, 4'b1111, 7'b1111111, 1'b1};
        vecs[4] = '{16'hABCD, 4'h0, 1'b1, 1'b0, 0, 4'b1110, 7'b1000010, 1'b1};
        vecs[5] = '{16'hABCD, 4'h0, 1'b1, 1'b0, 1, 4'b1101, 7'b0110001, 1'b1};
        vecs[6] = '{16'hABCD, 4'h0, 1'b1, 1'b0, 3, 4'b0111, 7'b0001000, 1'b1};
        vecs[7] = '{16'hABCD, 4'h0, 1'b0, 1'b0, 2, 4'b1011, 7'b1111110, 1'b1};
        vecs[8] = '{16'h1234, 4'h2, 1'b0, 1'b0, 1, 4'b1101, 7'b0000110, 1'b0};
        vecs[9] = '{16'h0000, 4'h0, 1'b0, 1'b1, 0, 4'b1110, 7'b0000001, 1'b1};

        // Table vectors: load in frame 0, inspect cnt_ref=0 of the target digit in frame 1
        for (int i = 0; i < 10; i++) begin
            do_reset();
            hex_mode = vecs[i].hex; lz_blank = vecs[i].lz; bright = 4'd15; blink_mask = '0;
            data_in = vecs[i].data; dp_in = vecs[i].dp; data_vld = 1'b1;
            step();
            data_vld = 1'b0;
            while (n < FRAME + vecs[i].dig * TIME_REF) step();
            step();
            chk($sformatf("vec%0d_sel", i), 32'(seg_sel), 32'(vecs[i].e_sel));
            chk($sformatf("vec%0d_ment", i), 32'(seg_ment), 32'(vecs[i].e_ment));
            chk($sformatf("vec%0d_dp", i), 32'(seg_dp), 32'(vecs[i].e_dp));
        end

        // Mid-frame strobe is held to frame end; a frame-end strobe lands next frame
        do_reset();
        hex_mode = 1'b0; lz_blank = 1'b0; bright = 4'd15; blink_mask = '0; data_in = '0; dp_in = '0;
        while (n < 20) step();
        data_in = 16'h1234; data_vld = 1'b1;
        step();
        data_vld = 1'b0; data_in = 16'hFFFF;
        while (n < 32) step();
        step();
        chk("hold_old", 32'(seg_ment), 32'(7'b0000001));
        tick_cnt = 0;
        while (n < FRAME) step();
        chk("tick_once", 32'(tick_cnt), 32'd1);
        step();
        chk("new_d0_sel", 32'(seg_sel), 32'(4'b1110));
        chk("new_d0_ment", 32'(seg_ment), 32'(7'b1001100));
        while (n < 2 * FRAME - 1) step();
        data_in = 16'h5678; data_vld = 1'b1;
        step();
        data_vld = 1'b0; data_in = '0;
        step();
        chk("fe_load", 32'(seg_ment), 32'(7'b0000000));
        while (n < 3 * FRAME) step();
        step();
        chk("fe_keep", 32'(seg_ment), 32'(7'b0000000));

        // Brightness: on-time per slot is bright+1 clocks at TIME_REF=16
        do_reset();
        bright = 4'd3;
        c0 = 0;
        for (int k = 0; k < FRAME; k++) begin step(); if (!seg_sel[0]) c0++; end
        chk("bright3_on", 32'(c0), 32'd4);
        bright = 4'd0;
        c0 = 0;
        for (int k = 0; k < FRAME; k++) begin step(); if (!seg_sel[0]) c0++; end
        chk("bright0_on", 32'(c0), 32'd1);

        // Blink on digit 0 and decimal point on digit 1
        do_reset();
        bright = 4'd15; blink_mask = 4'b0001; dp_in = 4'b0010; data_in = 16'h4321; data_vld = 1'b1;
        dpl1 = 0; dplx = 0;
        for (int f = 0; f < 4; f++) begin
            c0 = 0; c1 = 0;
            for (int k = 0; k < FRAME; k++) begin
                step();
                data_vld = 1'b0;
                if (!seg_sel[0]) c0++;
                if (!seg_sel[1]) c1++;
                if (!seg_dp && seg_sel == 4'b1101) dpl1++;
                if (!seg_dp && seg_sel != 4'b1101) dplx++;
            end
            chk($sformatf("blink_d0_f%0d", f), 32'(c0), (f < 2) ? 32'd16 : 32'd0);
            chk($sformatf("blink_d1_f%0d", f), 32'(c1), 32'd16);
        end
        chk("dp_d1_count", 32'(dpl1), 32'd48);
        chk("dp_other", 32'(dplx), 32'd0);

        // Random run against the model
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                data_vld = 1'b1;
                for (int j = 0; j < DIGITS; j++)
                    data_in[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dp_in = 4'($urandom);
            end else begin
                data_vld = 1'b0;
            end
            if ($urandom_range(0, 40) == 0) begin
                hex_mode   = 1'($urandom);
                lz_blank   = 1'($urandom);
                bright     = 4'($urandom);
                blink_mask = 4'($urandom);
            end
            step();
        end
        data_vld = 1'b0;

        // Reset in the middle of a scan restarts at digit 0 with cleared data
        do_reset();
        lz_blank = 1'b1; hex_mode = 1'b0; bright = 4'd15; blink_mask = '0;
        step();
        chk("post_rst_sel", 32'(seg_sel), 32'(4'b1110));
        chk("post_rst_ment", 32'(seg_ment), 32'(7'b0000001));
        while (n < TIME_REF) step();
        step();
        chk("post_rst_d1", 32'(seg_sel), 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
